// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the serial sequence path
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_tx_state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b0110;
  localparam logic       IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/seq_rot_shreg.sv
// rtl/seq_rot_shreg.sv - parallel-load rotate-left register with MSB tap
module seq_rot_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             load_i,
  input  logic [PAT_W-1:0] data_i,
  input  logic             rot_i,
  output logic             msb_o
);

  logic [PAT_W-1:0] r_shreg;

  // Load has priority over rotate; rotation keeps the pattern for the next repetition.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_shreg <= '0;
    end else if (load_i) begin
      r_shreg <= data_i;
    end else if (rot_i) begin
      r_shreg <= {r_shreg[PAT_W-2:0], r_shreg[PAT_W-1]};
    end
  end

  assign msb_o = r_shreg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB first, repeated frames
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEFAULT_PATTERN)
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             use_def_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_i,
  output logic             data_o,
  output logic             valid_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int             BW       = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(PAT_W - 1);

  seq_tx_state_t r_state, w_state_nxt;

  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic [CNT_W-1:0] r_rep, w_rep_nxt;
  logic             r_data, r_valid, r_frame, r_busy, r_done;
  logic             w_data_nxt, w_valid_nxt, w_frame_nxt, w_busy_nxt, w_done_nxt;

  logic [PAT_W-1:0] w_pat;
  logic [PAT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_rep_load;
  logic             w_load, w_rot, w_msb, w_last;

  assign w_pat      = use_def_i ? DEF_PATTERN : pattern_i;
  // The MSB goes straight into the output flop on accept, so the register
  // starts one rotation ahead and its tap always holds the next bit to send.
  assign w_load_val = {w_pat[PAT_W-2:0], w_pat[PAT_W-1]};
  assign w_rep_load = (repeat_i == '0) ? CNT_W'(1) : repeat_i;
  assign w_last     = (r_bit == LAST_BIT) && (r_rep == CNT_W'(1));

  seq_rot_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .load_i  (w_load),
    .data_i  (w_load_val),
    .rot_i   (w_rot),
    .msb_o   (w_msb)
  );

  // State, counters and output flops.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_rep   <= '0;
      r_data  <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_rep   <= w_rep_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_frame <= w_frame_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state, counter updates and next output values; abort forces idle.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_rep_nxt   = r_rep;
    w_data_nxt  = IDLE_LEVEL;
    w_valid_nxt = 1'b0;
    w_frame_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_rot       = 1'b0;
    if (abort_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            w_state_nxt = SHIFT;
            w_load      = 1'b1;
            w_bit_nxt   = '0;
            w_rep_nxt   = w_rep_load;
            w_data_nxt  = w_pat[PAT_W-1];
            w_valid_nxt = 1'b1;
            w_frame_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end
        SHIFT: begin
          w_busy_nxt = 1'b1;
          if (w_last) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_rot       = 1'b1;
            w_data_nxt  = w_msb;
            w_valid_nxt = 1'b1;
            if (r_bit == LAST_BIT) begin
              w_bit_nxt   = '0;
              w_rep_nxt   = r_rep - CNT_W'(1);
              w_frame_nxt = 1'b1;
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign frame_o = r_frame;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx
module tb_seq_pattern_tx;

  logic       clk_i = 1'b0;
  logic       n_rst_i;
  logic       start_i, abort_i, use_def_i;
  logic [3:0] pattern_i;
  logic [7:0] repeat_i;
  logic       data_o, valid_o, frame_o, busy_o, done_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   cyc;
    logic data;
    logic frame;
    logic done;
  } exp_t;

  exp_t sb[$];

  seq_pattern_tx dut (
    .clk_i     (clk_i),
    .n_rst_i   (n_rst_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .use_def_i (use_def_i),
    .pattern_i (pattern_i),
    .repeat_i  (repeat_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .frame_o   (frame_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented bit or done pulse consumes one scoreboard entry.
  always @(negedge clk_i) begin
    if (n_rst_i && (valid_o || done_o)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=valid%0d/done%0d expected=none (cycle %0d)",
                 valid_o, done_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_data", int'(data_o), int'(e.data));
        chk("out_valid", int'(valid_o), int'(!e.done));
        chk("out_frame", int'(frame_o), int'(e.frame));
        chk("out_done", int'(done_o), int'(e.done));
        chk("out_busy", int'(busy_o), 1);
      end
    end else if (!valid_o) begin
      chk("idle_data", int'(data_o), 1);
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_data"}, int'(data_o), 1);
    chk({name, "_valid"}, int'(valid_o), 0);
    chk({name, "_frame"}, int'(frame_o), 0);
    chk({name, "_busy"}, int'(busy_o), 0);
    chk({name, "_done"}, int'(done_o), 0);
  endtask

  // Issue a start; bits is the hand-computed serial stream, MSB first, n bits long.
  // push_done=0 / nexp limit the expectation for transfers that get cut short.
  task automatic send(input logic [3:0] pat, input logic use_def, input logic [7:0] rep,
                      input logic [31:0] bits, input int n, input int nexp, input bit push_done);
    int c0;
    exp_t e;
    c0        = cyc;
    start_i   = 1'b1;
    use_def_i = use_def;
    pattern_i = pat;
    repeat_i  = rep;
    for (int k = 0; k < nexp; k++) begin
      e.cyc   = c0 + 1 + k;
      e.data  = bits[n-1-k];
      e.frame = ((k % 4) == 0);
      e.done  = 1'b0;
      sb.push_back(e);
    end
    if (push_done) begin
      e.cyc   = c0 + 1 + n;
      e.data  = 1'b1;
      e.frame = 1'b0;
      e.done  = 1'b1;
      sb.push_back(e);
    end
    tick();
    start_i   = 1'b0;
    use_def_i = 1'b0;
    pattern_i = 4'b1111;
    repeat_i  = 8'd9;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d pending expected=0", name, sb.size());
      sb.delete();
    end
    tick();
    chk_idle({name, "_after"});
  endtask

  initial begin
    n_rst_i   = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    use_def_i = 1'b0;
    pattern_i = 4'b0000;
    repeat_i  = 8'd0;
    tick();
    tick();
    chk_idle("reset");
    n_rst_i = 1'b1;
    tick();

    // Default pattern 0110 once.
    send(4'b0000, 1'b1, 8'd1, 32'b0110, 4, 4, 1'b1);
    drain("def_x1");
    // 1001 three times back-to-back; start lands in cycle N+2 of the previous transfer.
    send(4'b1001, 1'b0, 8'd3, 32'b1001_1001_1001, 12, 12, 1'b1);
    drain("pat_x3");
    // Repeat count zero behaves as one.
    send(4'b1010, 1'b0, 8'd0, 32'b1010, 4, 4, 1'b1);
    drain("rep0");

    // Start and new inputs during SHIFT are ignored.
    send(4'b1001, 1'b0, 8'd1, 32'b1001, 4, 4, 1'b1);
    start_i   = 1'b1;
    use_def_i = 1'b1;
    pattern_i = 4'b1111;
    repeat_i  = 8'd7;
    tick();
    tick();
    start_i = 1'b0;
    drain("restart_ignored");

    // Abort sampled at edge 2: only bit 0 appears, no done.
    send(4'b0000, 1'b1, 8'd1, 32'b0110, 4, 1, 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk_idle("abort");
    tick();
    send(4'b0011, 1'b0, 8'd2, 32'b0011_0011, 8, 8, 1'b1);
    drain("after_abort");

    // Abort together with start in IDLE sends nothing.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    tick();
    tick();
    chk_idle("abort_start");

    // Asynchronous reset between edges mid-SHIFT.
    send(4'b1001, 1'b0, 8'd2, 32'b1001_1001, 8, 8, 1'b1);
    tick();
    #2;
    n_rst_i = 1'b0;
    #1;
    chk_idle("async_rst");
    sb.delete();
    tick();
    n_rst_i = 1'b1;
    tick();
    send(4'b0000, 1'b1, 8'd1, 32'b0110, 4, 4, 1'b1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter. On a start request it latches a PAT_W-bit pattern and a repeat count, then shifts the pattern out MSB-first, one bit per clock, the requested number of times. It then pulses done. It is the stimulus/transmit side of the team's serial sequence-detection path. Its default pattern is 4'b0110, and its idle line level is 1, so a downstream detector sees no spurious pattern while the transmitter is idle.

## Interface
- PAT_W, 4, pattern width in bits (≥ 2)
- CNT_W, 8, repeat-count width
- DEF_PATTERN, 4'b0110 (PAT_W bits), pattern used when use_def_i = 1
- clk_i  in  1  clock, rising edge
- n_rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start request, sampled in IDLE only
- abort_i  in  1  synchronous abort, highest priority after reset
- use_def_i  in  1  1: transmit DEF_PATTERN; 0: transmit pattern_i (sampled with start_i)
- pattern_i  in  PAT_W  pattern to send, MSB first
- repeat_i  in  CNT_W  number of repetitions; 0 treated as 1
- data_o  out  1  serial data; idle level 1
- valid_o  out  1  data_o carries a pattern bit this cycle
- frame_o  out  1  high on the first (MSB) bit of every repetition
- busy_o  out  1  transfer in progress, including the DONE cycle
- done_o  out  1  one-cycle pulse after the last bit

## Operation
- Reset values: data_o = 1; valid_o, frame_o, busy_o, done_o = 0; state IDLE; counters 0.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE behaviour:
  - start_i = 1 latches the pattern (DEF_PATTERN or pattern_i) into the shift register.
  - It latches max(repeat_i, 1) into the repeat counter, clears the bit counter, and goes to SHIFT.
- SHIFT behaviour, each cycle:
  - data_o = shreg[PAT_W-1]; valid_o = 1; frame_o = (bit_cnt == 0).
  - The shift register rotates left by one, so the pattern is reloaded for the next repetition without re-sampling inputs.
- Bit counter: width $clog2(PAT_W). It wraps from PAT_W-1 to 0 and decrements the repeat counter on each wrap.
- End of transfer: on the last bit of the last repetition, go to DONE.
- DONE behaviour: lasts exactly one cycle.
  - done_o = 1, valid_o = 0, data_o = 1, busy_o = 1.
  - Then go to IDLE.
- Input sampling rules:
  - start_i in SHIFT or DONE is ignored (not queued).
  - pattern_i, use_def_i and repeat_i are ignored except in the cycle start_i is accepted.
- abort_i = 1 in any state forces IDLE on the next edge.
  - Outputs return to reset values.
  - No done_o pulse.
  - abort_i together with start_i in IDLE: abort wins, nothing is sent.
- Asynchronous reset mid-transfer immediately forces all outputs to reset values. The partial frame is lost.
- Total bits per transfer = PAT_W × max(repeat_i, 1). Maximum = PAT_W × (2^CNT_W − 1).

## Timing
- start_i high in cycle 0 (sampled at edge 1), then:
  - Bit 0 (MSB) is on data_o during cycle 1, with valid_o = frame_o = 1.
  - Bit k of the transfer is on data_o in cycle 1+k.
  - Last bit is in cycle N = PAT_W·R, where R = max(repeat_i, 1).
  - done_o is high in cycle N+1.
  - busy_o is high in cycles 1..N+1.
  - The next start_i is accepted when sampled in cycle N+2 or later.
- Throughput is one bit per clock with no gap between repetitions. frame_o marks each repetition boundary.
- abort_i sampled at edge k: outputs are idle from cycle k.

## Structure
- Shared package seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_tx_state_t
  - DEFAULT_PATTERN = 4'b0110
  - IDLE_LEVEL = 1'b1
- One natural sub-module: seq_rot_shreg, a PAT_W-bit parallel-load, rotate-left register with MSB tap.
- The FSM and the two counters stay in the top module.

## Test plan
- Reset, then start_i with use_def_i = 1, repeat_i = 1 -> data_o = 0,1,1,0 in cycles 1–4; frame_o only in cycle 1; done_o in cycle 5; busy_o cycles 1–5; data_o = 1 from cycle 5.
- pattern_i = 4'b1001, use_def_i = 0, repeat_i = 3 -> 12 bits 1001 1001 1001 back-to-back; frame_o in cycles 1, 5, 9; done_o in cycle 13.
- repeat_i = 0 -> identical to repeat_i = 1, i.e. 4 bits then done_o.
- start_i re-asserted and pattern_i changed during SHIFT -> ignored; the original pattern completes and exactly one done_o pulse occurs.
- abort_i in cycle 2 of a 4-bit frame -> from cycle 2 data_o = 1, valid_o = busy_o = 0; done_o never pulses; a new start in cycle 3 is accepted normally.
- n_rst_i asserted mid-SHIFT (asynchronously, between edges) -> outputs reach reset values without a clock edge; after release, the first start behaves as in scenario 1.
